// File: rtl/sys_time_sync_ctrl_pkg.sv
// Shared types and helpers for the SYS_TIME alignment block.
// Holds the controller state encoding and the error saturation helper.
package sys_time_pkg;

    localparam int SYS_TIME_W = 64;
    localparam int ERR_W      = 32;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        WAIT_SET   = 2'd1,
        WAIT_FIRST = 2'd2,
        RUN        = 2'd3
    } sync_state_e;

    // Clamp a signed 64-bit error into the signed 32-bit ERR range.
    function automatic logic signed [ERR_W-1:0] sat_err(
        input logic signed [SYS_TIME_W-1:0] v
    );
        logic [SYS_TIME_W-ERR_W:0] sign_ext;
        sign_ext = {(SYS_TIME_W-ERR_W+1){v[SYS_TIME_W-1]}};
        if (v[SYS_TIME_W-1:ERR_W-1] == sign_ext)
            return v[ERR_W-1:0];
        else if (v[SYS_TIME_W-1])
            return {1'b1, {(ERR_W-1){1'b0}}};
        else
            return {1'b0, {(ERR_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/sys_time_sync_ctrl_if.sv
// Configuration and status bundle between the controller register
// block (master) and the SYS_TIME alignment block (slave).
interface sys_time_sync_ctrl_if;

    logic                              SET;
    logic [sys_time_pkg::SYS_TIME_W-1:0] SYNC_TIME;
    logic [31:0]                       SYNC_CYCLE;
    logic [sys_time_pkg::SYS_TIME_W-1:0] SYS_TIME;
    logic                              SYNCED;
    logic [sys_time_pkg::ERR_W-1:0]    ERR;
    logic                              SLEWING;

    modport master (
        output SET, SYNC_TIME, SYNC_CYCLE,
        input  SYS_TIME, SYNCED, ERR, SLEWING
    );

    modport slave (
        input  SET, SYNC_TIME, SYNC_CYCLE,
        output SYS_TIME, SYNCED, ERR, SLEWING
    );

endinterface

// File: rtl/sys_time_sync_ctrl_sync0_edge_det.sv
// Two-flop synchronizer plus rising-edge pulse for an asynchronous
// ESC input; the pulse is exactly one clock wide.
module sync0_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sh_q;

    // Shift the pin through two metastability flops and one history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sh_q <= '0;
        else
            sh_q <= {sh_q[1:0], din};
    end

    assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/sys_time_sync_ctrl.sv
// Global SYS_TIME counter aligned to the EtherCAT SYNC0 pulse:
// hard load on first edge, +-1 tick slewing, hard reload on large error.
module sys_time_sync_ctrl
    import sys_time_pkg::*;
#(
    parameter int unsigned SYNC_LATENCY    = 3,
    parameter int unsigned ADJUST_INTERVAL = 256,
    parameter int unsigned MAX_ERR         = 4096
) (
    input  logic                 CLK_163P84M,
    input  logic                 RESET_N,
    input  logic                 LOCKED,
    input  logic                 SYNC0,
    sys_time_sync_ctrl_if.slave  cfg
);

    localparam int ADJ_W = $clog2(ADJUST_INTERVAL);
    localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJUST_INTERVAL - 1);
    localparam logic [SYS_TIME_W-1:0] LAT = SYS_TIME_W'(SYNC_LATENCY);
    localparam logic signed [SYS_TIME_W-1:0] MAX_POS = SYS_TIME_W'(MAX_ERR);
    localparam logic signed [SYS_TIME_W-1:0] MAX_NEG = -MAX_POS;

    sync_state_e state_q, state_d;

    logic                         edge_e;
    logic [SYS_TIME_W-1:0]        sys_time_q, time_d;
    logic [SYS_TIME_W-1:0]        target_q, target_d;
    logic [31:0]                  cycle_q, cycle_d;
    logic                         synced_q, synced_d;
    logic signed [ERR_W-1:0]      err_q, err_d;
    logic signed [ERR_W-1:0]      resid_q, resid_d;
    logic signed [SYS_TIME_W-1:0] meas_q, meas_d;
    logic                         apply_q, apply_d;
    logic [ADJ_W-1:0]             adj_cnt_q;
    logic                         adj_fire;

    logic signed [SYS_TIME_W-1:0] meas_err;
    logic                         hard_err;
    logic                         lock_lost;
    logic                         do_set;
    logic                         do_first;
    logic                         do_meas;
    logic                         in_run;

    sync0_edge_det u_sync0 (
        .clk   (CLK_163P84M),
        .rst_n (RESET_N),
        .din   (SYNC0),
        .rise  (edge_e)
    );

    // Error of the current count against where the edge says it should be.
    assign meas_err = target_q + LAT - sys_time_q - 64'd1;
    assign hard_err = (meas_q > MAX_POS) || (meas_q < MAX_NEG);
    assign adj_fire = (adj_cnt_q == ADJ_LAST);
    assign in_run   = (state_q == RUN);

    // Free-running slew pacing counter.
    always_ff @(posedge CLK_163P84M or negedge RESET_N) begin
        if (!RESET_N)
            adj_cnt_q <= '0;
        else if (adj_fire)
            adj_cnt_q <= '0;
        else
            adj_cnt_q <= adj_cnt_q + ADJ_W'(1);
    end

    // Controller state register.
    always_ff @(posedge CLK_163P84M or negedge RESET_N) begin
        if (!RESET_N)
            state_q <= WAIT_LOCK;
        else
            state_q <= state_d;
    end

    // Next state; lock loss beats SET, and SET beats a same-cycle edge.
    always_comb begin
        state_d   = state_q;
        lock_lost = 1'b0;
        do_set    = 1'b0;
        do_first  = 1'b0;
        do_meas   = 1'b0;
        if (!LOCKED) begin
            state_d   = WAIT_LOCK;
            lock_lost = 1'b1;
        end else begin
            unique case (state_q)
                WAIT_LOCK: state_d = WAIT_SET;
                WAIT_SET: begin
                    if (cfg.SET) begin
                        do_set  = 1'b1;
                        state_d = WAIT_FIRST;
                    end
                end
                WAIT_FIRST: begin
                    if (cfg.SET) begin
                        do_set = 1'b1;
                    end else if (edge_e) begin
                        do_first = 1'b1;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (cfg.SET) begin
                        do_set  = 1'b1;
                        state_d = WAIT_FIRST;
                    end else if (edge_e) begin
                        do_meas = 1'b1;
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    // Time, target and residual updates for the current cycle.
    always_comb begin
        time_d   = sys_time_q;
        target_d = target_q;
        cycle_d  = cycle_q;
        synced_d = synced_q;
        err_d    = err_q;
        resid_d  = resid_q;
        meas_d   = meas_q;
        apply_d  = 1'b0;
        unique case (1'b1)
            lock_lost: begin
                synced_d = 1'b0;
                resid_d  = '0;
            end
            do_set: begin
                time_d   = sys_time_q + 64'd1;
                target_d = cfg.SYNC_TIME;
                cycle_d  = cfg.SYNC_CYCLE;
                synced_d = 1'b0;
                resid_d  = '0;
            end
            do_first: begin
                time_d   = target_q + LAT;
                target_d = target_q + 64'(cycle_q);
                synced_d = 1'b1;
                err_d    = '0;
            end
            do_meas: begin
                time_d   = sys_time_q + 64'd1;
                target_d = target_q + 64'(cycle_q);
                err_d    = sat_err(meas_err);
                meas_d   = meas_err;
                apply_d  = 1'b1;
            end
            default: begin
                if (in_run && apply_q) begin
                    if (hard_err) begin
                        time_d  = sys_time_q + 64'd1 + $unsigned(meas_q);
                        resid_d = '0;
                    end else begin
                        time_d  = sys_time_q + 64'd1;
                        resid_d = meas_q[ERR_W-1:0];
                    end
                end else if (in_run && adj_fire && resid_q > 0) begin
                    time_d  = sys_time_q + 64'd2;
                    resid_d = resid_q - 32'sd1;
                end else if (in_run && adj_fire && resid_q < 0) begin
                    resid_d = resid_q + 32'sd1;
                end else if (state_q != WAIT_LOCK) begin
                    time_d = sys_time_q + 64'd1;
                end
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK_163P84M or negedge RESET_N) begin
        if (!RESET_N) begin
            sys_time_q <= '0;
            target_q   <= '0;
            cycle_q    <= '0;
            synced_q   <= 1'b0;
            err_q      <= '0;
            resid_q    <= '0;
            meas_q     <= '0;
            apply_q    <= 1'b0;
        end else begin
            sys_time_q <= time_d;
            target_q   <= target_d;
            cycle_q    <= cycle_d;
            synced_q   <= synced_d;
            err_q      <= err_d;
            resid_q    <= resid_d;
            meas_q     <= meas_d;
            apply_q    <= apply_d;
        end
    end

    assign cfg.SYS_TIME = sys_time_q;
    assign cfg.SYNCED   = synced_q;
    assign cfg.ERR      = err_q;
    assign cfg.SLEWING  = (resid_q != '0);

endmodule

// File: doc/sys_time_sync_ctrl.md
Name: sys_time_sync_ctrl

Overview:
- Owns the 64-bit global SYS_TIME counter (163.84 MHz ticks) consumed by modulation, STM and PWM timing.
- Aligns SYS_TIME to the EtherCAT distributed-clock SYNC0 pulse: hard-loads it on the first edge, then slews it by ±1 tick steps to remove residual drift, with a hard reload for large errors.
- Sits between the clock generator (CLK_163P84M, LOCKED) and all time consumers; configured by the controller register block.

Parameters:
- SYNC_LATENCY, 3, ticks between the SYNC0 pin edge and its detection; added to every target.
- ADJUST_INTERVAL, 256, cycles between consecutive slew steps (≥2).
- MAX_ERR, 4096, |error| above which a hard reload replaces slewing.

Ports:
- CLK_163P84M  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- LOCKED  in  1  PLL locked (synchronous to CLK)
- SYNC0  in  1  ESC SYNC0 pulse, asynchronous
- SET  in  1  one-cycle strobe: latch SYNC_TIME and SYNC_CYCLE, (re)start sync
- SYNC_TIME  in  64  SYS_TIME value required at the next SYNC0 edge
- SYNC_CYCLE  in  32  SYNC0 period in ticks (nonzero)
- SYS_TIME  out  64  global time
- SYNCED  out  1  high after the first hard load, while in RUN
- ERR  out  32  last measured error, signed and saturated
- SLEWING  out  1  residual error nonzero

Behaviour:
- Reset: SYS_TIME=0, SYNCED=0, ERR=0, SLEWING=0, state=WAIT_LOCK, target=0, residual=0.
- SYNC0 passes through a 2-FF synchronizer and a rising-edge detector. The edge cycle E is one cycle long; pin-to-E latency is SYNC_LATENCY.
- States:
  - WAIT_LOCK: SYS_TIME holds. LOCKED=1 -> WAIT_SET.
  - WAIT_SET: SYS_TIME increments +1 per cycle. SET -> WAIT_FIRST (target=SYNC_TIME, cycle=SYNC_CYCLE).
  - WAIT_FIRST: +1 per cycle. At E: SYS_TIME <= target+SYNC_LATENCY; target += cycle; SYNCED<=1; ERR<=0; -> RUN.
  - RUN: at E, compute err = target+SYNC_LATENCY−(SYS_TIME+1) as signed 64-bit, saturated to 32 bits into ERR. Then target += cycle. SYS_TIME still takes +1 at E.
    - Cycle E+1, |err|>MAX_ERR: SYS_TIME <= SYS_TIME+1+err (exact correction); residual=0.
    - Cycle E+1, otherwise: residual <= err. A new E overwrites the residual, since err already includes it.
- Slew: a free counter fires every ADJUST_INTERVAL cycles. On a firing cycle with residual>0: step +2, residual−1. With residual<0: step +0, residual+1. Otherwise step +1. SLEWING = (residual≠0).
- SET in RUN or WAIT_FIRST: reload target/cycle, SYNCED<=0, residual=0, -> WAIT_FIRST. If SET and E occur in the same cycle, SET wins and that edge is ignored.
- LOCKED=0 in any state: -> WAIT_LOCK, SYNCED=0, residual=0. SYS_TIME holds its value. Target and cycle are retained, but a new SET is required.
- SYS_TIME wraps modulo 2^64 with no flag. Target arithmetic is also modulo 2^64.
- Asynchronous reset mid-operation restores all reset values immediately.

Decomposition:
- Package sys_time_pkg: state enum (WAIT_LOCK, WAIT_SET, WAIT_FIRST, RUN), SYS_TIME_W=64, ERR_W=32, and the saturate-to-32 function.
- Sub-module sync0_edge_det: 2-FF synchronizer plus rising-edge pulse. It is reused elsewhere for other ESC inputs.

Test Plan:
1. Reset, LOCKED=1, SET with SYNC_TIME=1000, SYNC_CYCLE=81920, SYNC0 edge -> SYS_TIME=1003 the cycle after E; SYNCED=1.
2. Second edge exactly 81920 ticks later -> ERR=0, SLEWING=0, SYS_TIME continues +1 per cycle.
3. Second edge 5 ticks late (SYS_TIME 5 ahead of target) -> ERR=−5; five skipped increments at 256-cycle intervals; SLEWING clears after the 5th step.
4. Edge 10000 ticks early (err=+10000 > MAX_ERR) -> SYS_TIME jumps by 10001 at E+1; residual=0; SLEWING=0.
5. SET asserted in the same cycle as E while in RUN -> edge ignored, SYNCED=0, next edge hard-loads the new SYNC_TIME+3.
6. Drop LOCKED in RUN, then reset pulse mid-slew -> SYS_TIME holds, then all outputs return to 0; re-lock requires SET before SYNCED returns.
